// File: rtl/fp_mul_issue.sv
// rtl/fp_mul_issue.sv - issue/capture stage wrapped around a combinational FP32 multiplier
//
// Registers an operand pair onto the multiplier inputs, holds them for a
// multi-cycle path of WAIT_CYCLES cycles, then captures the product and flags.
//
// Parameters:
//   WAIT_CYCLES  cycles the multiplier inputs are held before capture (1..15)
//   CNT_W        width of the completed-operation counter
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   start         multiply request, sampled only in IDLE
//   op_a, op_b    operands, sampled with an accepted start
//   mul_a, mul_b  registered operands driven to the multiplier
//   mul_result    product returned by the multiplier
//   mul_flags     multiplier flags {negative, carry, zero, overflow}
//   busy          high in WAIT or CAPTURE
//   done          one-cycle pulse after a capture
//   result        last captured product
//   flags         last captured flags
//   sticky_flags  OR of every captured flags value since reset/clear
//   clr_sticky    clear sticky_flags
//   ops_done      count of completed operations (wraps)

module fp_mul_issue #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_result,
  input  logic [3:0]       mul_flags,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic [3:0]       flags,
  output logic [3:0]       sticky_flags,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  // WAIT exits when cnt reaches zero, so loading WAIT_CYCLES-1 gives
  // exactly WAIT_CYCLES cycles in WAIT.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  localparam logic [CNT_W-1:0] OPS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [3:0] cnt;

  assign busy = (state == S_WAIT) || (state == S_CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      mul_a        <= 32'd0;
      mul_b        <= 32'd0;
      result       <= 32'd0;
      flags        <= 4'd0;
      sticky_flags <= 4'd0;
      ops_done     <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;

      // Outside CAPTURE a clear simply zeroes the accumulator; inside CAPTURE
      // the clear is folded into the accumulate below.
      if (clr_sticky && (state != S_CAPTURE)) begin
        sticky_flags <= 4'd0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            mul_a <= op_a;
            mul_b <= op_b;
            cnt   <= CNT_LOAD;
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_CAPTURE: begin
          result       <= mul_result;
          flags        <= mul_flags;
          sticky_flags <= (clr_sticky ? 4'd0 : sticky_flags) | mul_flags;
          ops_done     <= ops_done + OPS_ONE;
          done         <= 1'b1;
          state        <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_issue.sv
// tb/tb_fp_mul_issue.sv - scoreboard bench for fp_mul_issue with a behavioural multiplier model

module tb_fp_mul_issue;

  localparam int W  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic [31:0]   mul_result;
  logic [3:0]    mul_flags;
  logic          busy;
  logic          done;
  logic [31:0]   result;
  logic [3:0]    flags;
  logic [3:0]    sticky_flags;
  logic          clr_sticky;
  logic [CW-1:0] ops_done;

  always #5 clk = ~clk;

  fp_mul_issue #(.WAIT_CYCLES(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_result   (mul_result),
    .mul_flags    (mul_flags),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .flags        (flags),
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky),
    .ops_done     (ops_done)
  );

  // Simple truncating FP32 multiplier used as the environment; returns {flags, product}.
  function automatic logic [35:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic        c;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {4'b0010, s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    c = p[47];
    if (c) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, c, 1'b0, 1'b1, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, c, 1'b1, 1'b0, s, 31'd0};
    return {s, c, 2'b00, s, 8'(e), m};
  endfunction

  assign {mul_flags, mul_result} = fmul(mul_a, mul_b);

  typedef struct {
    int          edge_n;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int next_free = 0;
  bit mon_en = 1'b0;

  logic [31:0]   m_result, m_mul_a, m_mul_b;
  logic [3:0]    m_flags, m_sticky;
  logic [CW-1:0] m_ops;
  bit            pend_valid = 1'b0;
  int            pend_edge;
  logic [31:0]   pend_res;
  logic [3:0]    pend_flg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model across the edge.
  task automatic step(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic r);
    start = s; op_a = a; op_b = b; clr_sticky = c; reset = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      sb_q.delete();
      pend_valid = 1'b0;
      m_result = '0; m_flags = '0; m_sticky = '0; m_ops = '0;
      m_mul_a = '0; m_mul_b = '0;
      next_free = cyc + 1;
    end else begin
      if (pend_valid && pend_edge == cyc) begin
        m_result = pend_res;
        m_flags  = pend_flg;
        m_sticky = (c ? 4'd0 : m_sticky) | pend_flg;
        m_ops    = m_ops + 1'b1;
        pend_valid = 1'b0;
      end else if (c) begin
        m_sticky = 4'd0;
      end
      if (s && cyc >= next_free) begin
        {pend_flg, pend_res} = fmul(a, b);
        pend_edge  = cyc + W + 1;
        pend_valid = 1'b1;
        next_free  = cyc + W + 2;
        m_mul_a = a;
        m_mul_b = b;
        sb_q.push_back('{cyc + W + 1, pend_res, pend_flg});
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    step(1'b1, a, b, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((pend_valid || cyc < next_free) && guard < 100) begin
      idle();
      guard++;
    end
    if (guard >= 100) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: compares held outputs against the model every cycle and pops the
  // scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("busy", {31'd0, busy}, {31'd0, (cyc < next_free - 1)});
      chk("result", result, m_result);
      chk("flags", {28'd0, flags}, {28'd0, m_flags});
      chk("sticky", {28'd0, sticky_flags}, {28'd0, m_sticky});
      chk("ops_done", 32'(ops_done), 32'(m_ops));
      chk("mul_a", mul_a, m_mul_a);
      chk("mul_b", mul_b, m_mul_b);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.edge_n));
          chk("done_result", result, e.res);
          chk("done_flags", {28'd0, flags}, {28'd0, e.flg});
        end
      end else if (sb_q.size() > 0 && sb_q[0].edge_n <= cyc) begin
        e = sb_q.pop_front();
        chk("done_missing", 32'(cyc), 32'(e.edge_n));
      end
    end
  end

  initial begin
    int ops_before;
    int dones;
    start = 0; op_a = 0; op_b = 0; clr_sticky = 0; reset = 1;

    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ops", 32'(ops_done), 32'd0);
    idle();

    // 2.0 x 3.0
    issue(32'h4000_0000, 32'h4040_0000);
    wait_idle();
    chk("plan_2x3_result", result, 32'h40C0_0000);
    chk("plan_2x3_flags", {28'd0, flags}, 32'h0);
    chk("plan_2x3_ops", 32'(ops_done), 32'd1);

    // -2.0 x 3.0
    issue(32'hC000_0000, 32'h4040_0000);
    wait_idle();
    chk("plan_neg_result", result, 32'hC0C0_0000);
    chk("plan_neg_flags", {28'd0, flags}, 32'h8);
    chk("plan_neg_sticky", {28'd0, sticky_flags}, 32'h8);

    // overflow, then zero
    issue(32'h7F00_0000, 32'h7F00_0000);
    wait_idle();
    chk("plan_ovf_result", result, 32'h7F80_0000);
    chk("plan_ovf_flags", {28'd0, flags}, 32'h1);
    issue(32'h0000_0000, 32'h40A0_0000);
    wait_idle();
    chk("plan_zero_result", result, 32'h0000_0000);
    chk("plan_zero_flags", {28'd0, flags}, 32'h2);
    chk("plan_zero_sticky", {28'd0, sticky_flags}, 32'hB);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("plan_clr_idle", {28'd0, sticky_flags}, 32'h0);

    // start during WAIT is ignored; start in the done cycle is accepted
    ops_before = int'(ops_done);
    issue(32'h4000_0000, 32'h4040_0000);
    step(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
    chk("plan_ignore_mul_a", mul_a, 32'h4000_0000);
    dones = 0;
    while (cyc + 1 < next_free) begin
      idle();
      if (done) dones++;
    end
    chk("plan_ignore_one_done", 32'(dones), 32'd1);
    chk("plan_ignore_ops", 32'(ops_done), 32'(ops_before + 1));
    issue(32'h3F80_0000, 32'h4040_0000);
    chk("plan_b2b_mul_a", mul_a, 32'h3F80_0000);
    wait_idle();

    // reset during WAIT aborts the op
    issue(32'h4000_0000, 32'h4040_0000);
    idle();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("plan_abort_busy", {31'd0, busy}, 32'd0);
    chk("plan_abort_result", result, 32'd0);
    chk("plan_abort_ops", 32'(ops_done), 32'd0);
    repeat (6) idle();

    // clr_sticky coincident with CAPTURE
    issue(32'h7F00_0000, 32'h7F00_0000);      wait_idle();
    issue(32'h0000_0000, 32'h40A0_0000);      wait_idle();
    issue(32'hC000_0000, 32'h4040_0000);      wait_idle();
    chk("plan_sticky_1011", {28'd0, sticky_flags}, 32'hB);
    issue(32'h4000_0000, 32'h4040_0000);
    while (pend_valid) begin
      step(1'b0, 32'd0, 32'd0, (cyc + 1 == pend_edge), 1'b0);
    end
    chk("plan_clr_capture", {28'd0, sticky_flags}, 32'h0);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a[30:0] = 31'd0;
        1: begin a[30:23] = 8'hF0; b[30:23] = 8'hC0; end
        2: begin a[30:23] = 8'h10; b[30:23] = 8'h20; end
        default: ;
      endcase
      step($urandom_range(0, 2) != 0, a, b,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    wait_idle();
    repeat (3) idle();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mul_issue.md
Name: fp_mul_issue

Overview:
- Sequential issue/capture stage that sits directly upstream of the combinational single-precision multiplier (FloatingPointMul32) in the multi-cycle datapath.
- Accepts an operand pair on a start pulse and registers it onto the multiplier inputs.
- Holds those inputs stable for a programmable multi-cycle path, then captures the product and the 4-bit flags.
- Signals completion with a one-cycle done pulse and maintains sticky (accumulated) flags for the control unit.

Parameters:
- WAIT_CYCLES, 2, number of cycles the multiplier inputs are held stable before capture; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- op_a  in  32  IEEE-754 single operand A, sampled with start.
- op_b  in  32  IEEE-754 single operand B, sampled with start.
- mul_a  out  32  registered operand A driven to the multiplier.
- mul_b  out  32  registered operand B driven to the multiplier.
- mul_result  in  32  product returned by the multiplier.
- mul_flags  in  4  multiplier flags {negative, carry(unused), zero, overflow} as bits [3..0].
- busy  out  1  high while an operation is in flight (WAIT or CAPTURE).
- done  out  1  one-cycle pulse: result/flags were updated at the preceding edge.
- result  out  32  last captured product; held until the next capture.
- flags  out  4  last captured flags; held until the next capture.
- sticky_flags  out  4  OR-accumulation of every captured flags value since reset/clear.
- clr_sticky  in  1  clear sticky_flags.
- ops_done  out  CNT_W  count of completed operations.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - State goes to IDLE.
  - mul_a, mul_b, result, flags, sticky_flags, ops_done and the internal counter all go to 0.
  - busy=0, done=0.
  - Reset overrides every other input.
- FSM states: IDLE, WAIT, CAPTURE.
- busy is a combinational decode: busy=1 exactly in WAIT or CAPTURE.
- IDLE:
  - If start=1: mul_a<=op_a, mul_b<=op_b, cnt<=WAIT_CYCLES-1, go to WAIT.
  - Otherwise stay in IDLE; mul_a and mul_b hold.
- WAIT:
  - If cnt==0, go to CAPTURE; otherwise cnt<=cnt-1.
  - WAIT therefore lasts exactly WAIT_CYCLES cycles.
  - mul_a and mul_b are stable throughout.
- CAPTURE (one cycle):
  - result<=mul_result, flags<=mul_flags.
  - sticky_flags<=sticky_flags|mul_flags.
  - ops_done<=ops_done+1, wrapping modulo 2^CNT_W.
  - done<=1, go to IDLE.
- done is registered and is high for exactly the one cycle after CAPTURE; it is 0 in all other cycles.
- Latency: start sampled at edge k, then done=1 during the cycle after edge k+WAIT_CYCLES+1.
- Back-to-back operation: start=1 in the IDLE cycle in which done=1 is accepted. Sustained throughput is one op per WAIT_CYCLES+2 cycles.
- start while busy=1 is ignored, with no queueing. op_a and op_b are don't-care outside the accepting cycle.
- clr_sticky:
  - In a non-capture cycle: sticky_flags<=0.
  - Coinciding with CAPTURE: sticky_flags<=mul_flags (clear first, then accumulate the new op).
- Reset mid-operation aborts the op:
  - No done pulse is produced.
  - result, flags and ops_done are zeroed, not updated.
- The block performs no arithmetic on the data. Flag meanings are the multiplier's: [0] overflow→Inf, [1] zero/underflow, [3] negative result. Bit [2] is passed through and accumulated unchanged.

Test Plan:
- WAIT_CYCLES=2: op_a=0x40000000 (2.0), op_b=0x40400000 (3.0), start at edge 0 → busy=1 for cycles 1..3, done=1 in cycle 4 only, result=0x40C00000, flags=0000, ops_done=1.
- op_a=0xC0000000 (-2.0), op_b=0x40400000 → result=0xC0C00000, flags=1000; sticky_flags=1000 accumulated with the previous 0000.
- op_a=0x7F000000, op_b=0x7F000000 → result=0x7F800000, flags=0001. Then 0x00000000×0x40A00000 → result=0x00000000, flags=0010, sticky_flags=1011. Pulse clr_sticky in an idle cycle → sticky_flags=0000.
- start re-asserted with op_a=0x3F800000 during WAIT → ignored: mul_a unchanged, exactly one done, ops_done increments by 1. Then start in the done cycle → accepted, second done 4 cycles later.
- reset=1 during WAIT → next cycle busy=0, done never pulses, result=0, ops_done=0. clr_sticky coincident with CAPTURE of the 2.0×3.0 op, with sticky=1011 → sticky_flags=0000.
